// File: rtl/n64_pkg.sv
// n64_pkg: shared state encoding, joybus command codes and bit-timing
// constants for the N64 poll sequencer.
`timescale 1ns/1ps
package n64_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TX_BIT,
    TX_STOP,
    RX_WAIT,
    RX_SAMPLE,
    DONE
  } n64_state_t;

  localparam logic [7:0] N64_CMD_POLL = 8'h01;
  localparam logic [7:0] N64_CMD_INFO = 8'h00;

  // Host bit cell: 4us, low for 3us (zero) or 1us (one).
  localparam int LOW0_US     = 3;
  localparam int LOW1_US     = 1;
  localparam int BIT_US      = 4;
  // Host stop bit: 1us low then 2us high before the bus is released.
  localparam int STOP_LOW_US = 1;
  localparam int STOP_US     = 3;
  // Reply bits are read this long after their falling edge.
  localparam int SAMPLE_US   = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/n64_us_tick.sv
// n64_us_tick: divides clk down to a one-cycle pulse every CLK_PER_US
// cycles. Counts only while enabled; a synchronous clear realigns the
// phase so the first microsecond of a transaction is a full one.
`timescale 1ns/1ps
module n64_us_tick #(
  parameter int CLK_PER_US = 4
) (
  input  logic clk,
  input  logic Reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int DW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_PER_US - 1);

  logic [DW-1:0] div_reg;

  // Free-running divider, wraps after CLK_PER_US cycles.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      div_reg <= '0;
    end else if (clear) begin
      div_reg <= '0;
    end else if (en) begin
      div_reg <= (div_reg == DIV_LAST) ? '0 : div_reg + DW'(1);
    end
  end

  assign tick = en && (div_reg == DIV_LAST);

endmodule

// File: rtl/n64_poll_sequencer.sv
// n64_poll_sequencer: joybus host. Sends a CMD_W-bit command MSB first
// with 1us/3us bit cells, then captures a RESP_W-bit reply by timing each
// falling edge and sampling 2us later. A missing edge aborts with a
// timeout strobe and leaves the previous reply untouched.
// Optional build macro N64_AUTO_POLL_EN adds a POLL_US periodic start.
`timescale 1ns/1ps
module n64_poll_sequencer
  import n64_pkg::*;
#(
  parameter int CLK_PER_US = 4,
  parameter int CMD_W      = 8,
  parameter int RESP_W     = 32,
  parameter int TIMEOUT_US = 64,
  parameter int POLL_US    = 16000
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [CMD_W-1:0]  cmd,
  input  logic              data_in,
  output logic              line_drive_low,
  output logic              busy,
  output logic              resp_valid,
  output logic [RESP_W-1:0] resp_data,
  output logic              timeout_err
);

  localparam int US_W        = $clog2(max_int(TIMEOUT_US, BIT_US) + 1);
  localparam int TXI_W       = max_int($clog2(CMD_W), 1);
  localparam int RX_W        = $clog2(RESP_W + 1);
  localparam int SAMPLE_CLKS = SAMPLE_US * CLK_PER_US;
  localparam int CYC_W       = max_int($clog2(SAMPLE_CLKS), 1);

  n64_state_t        state_reg, state_next;
  logic [CMD_W-1:0]  cmd_reg, cmd_next;
  logic [TXI_W-1:0]  bit_idx_reg, bit_idx_next;
  logic [US_W-1:0]   us_cnt_reg, us_cnt_next;
  logic [CYC_W-1:0]  cyc_cnt_reg, cyc_cnt_next;
  logic [RX_W-1:0]   rx_cnt_reg, rx_cnt_next;
  logic [RESP_W-1:0] rx_shift_reg, rx_shift_next;
  logic [RESP_W-1:0] resp_data_reg, resp_data_next;
  logic              resp_valid_reg, resp_valid_next;
  logic              timeout_err_reg, timeout_err_next;
  logic              sync1_reg, sync2_reg, prev_reg;
  logic              start_eff, accept, us_tick, fall_edge;

  assign accept    = start_eff && (state_reg == IDLE);
  assign fall_edge = prev_reg && !sync2_reg;

`ifdef N64_AUTO_POLL_EN
  localparam int POLL_CLKS = POLL_US * CLK_PER_US;
  localparam int PW        = $clog2(POLL_CLKS + 1);

  logic [PW-1:0] poll_cnt_reg;
  logic          poll_fire;

  assign poll_fire = (poll_cnt_reg == PW'(POLL_CLKS - 1));
  assign start_eff = start || poll_fire;

  // Poll interval timer: restarts on every accepted start, holds at expiry
  // until the sequencer is idle and takes the request.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      poll_cnt_reg <= '0;
    end else if (accept) begin
      poll_cnt_reg <= '0;
    end else if (!poll_fire) begin
      poll_cnt_reg <= poll_cnt_reg + PW'(1);
    end
  end
`else
  assign start_eff = start;
`endif

  n64_us_tick #(
    .CLK_PER_US(CLK_PER_US)
  ) u_us_tick (
    .clk  (clk),
    .Reset(Reset),
    .clear(accept),
    .en   (busy),
    .tick (us_tick)
  );

  // Two-stage synchroniser plus edge history; idle bus reads high.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      prev_reg  <= 1'b1;
    end else begin
      sync1_reg <= data_in;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_reg       <= IDLE;
      cmd_reg         <= '0;
      bit_idx_reg     <= '0;
      us_cnt_reg      <= '0;
      cyc_cnt_reg     <= '0;
      rx_cnt_reg      <= '0;
      rx_shift_reg    <= '0;
      resp_data_reg   <= '0;
      resp_valid_reg  <= 1'b0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cmd_reg         <= cmd_next;
      bit_idx_reg     <= bit_idx_next;
      us_cnt_reg      <= us_cnt_next;
      cyc_cnt_reg     <= cyc_cnt_next;
      rx_cnt_reg      <= rx_cnt_next;
      rx_shift_reg    <= rx_shift_next;
      resp_data_reg   <= resp_data_next;
      resp_valid_reg  <= resp_valid_next;
      timeout_err_reg <= timeout_err_next;
    end
  end

  // Next-state logic: transmit timing, edge-timed receive, timeout.
  always_comb begin
    state_next       = state_reg;
    cmd_next         = cmd_reg;
    bit_idx_next     = bit_idx_reg;
    us_cnt_next      = us_cnt_reg;
    cyc_cnt_next     = cyc_cnt_reg;
    rx_cnt_next      = rx_cnt_reg;
    rx_shift_next    = rx_shift_reg;
    resp_data_next   = resp_data_reg;
    resp_valid_next  = 1'b0;
    timeout_err_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          cmd_next     = cmd;
          bit_idx_next = TXI_W'(CMD_W - 1);
          us_cnt_next  = '0;
          state_next   = TX_BIT;
        end
      end
      TX_BIT: begin
        if (us_tick) begin
          if (us_cnt_reg == US_W'(BIT_US - 1)) begin
            us_cnt_next = '0;
            if (bit_idx_reg == '0) begin
              state_next = TX_STOP;
            end else begin
              bit_idx_next = bit_idx_reg - TXI_W'(1);
            end
          end else begin
            us_cnt_next = us_cnt_reg + US_W'(1);
          end
        end
      end
      TX_STOP: begin
        if (us_tick) begin
          if (us_cnt_reg == US_W'(STOP_US - 1)) begin
            us_cnt_next = '0;
            rx_cnt_next = '0;
            state_next  = RX_WAIT;
          end else begin
            us_cnt_next = us_cnt_reg + US_W'(1);
          end
        end
      end
      RX_WAIT: begin
        // An edge landing on the expiry cycle still counts as a reply bit.
        if (fall_edge) begin
          cyc_cnt_next = '0;
          state_next   = RX_SAMPLE;
        end else if (us_cnt_reg == US_W'(TIMEOUT_US)) begin
          timeout_err_next = 1'b1;
          state_next       = IDLE;
        end else if (us_tick) begin
          us_cnt_next = us_cnt_reg + US_W'(1);
        end
      end
      RX_SAMPLE: begin
        if (cyc_cnt_reg == CYC_W'(SAMPLE_CLKS - 1)) begin
          rx_shift_next = (rx_shift_reg << 1) | RESP_W'(sync2_reg);
          rx_cnt_next   = rx_cnt_reg + RX_W'(1);
          if (rx_cnt_reg == RX_W'(RESP_W - 1)) begin
            state_next = DONE;
          end else begin
            us_cnt_next = '0;
            state_next  = RX_WAIT;
          end
        end else begin
          cyc_cnt_next = cyc_cnt_reg + CYC_W'(1);
        end
      end
      DONE: begin
        resp_data_next  = rx_shift_reg;
        resp_valid_next = 1'b1;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Bus drive: low phase of each host bit and of the stop bit only.
  always_comb begin
    line_drive_low = 1'b0;
    case (state_reg)
      TX_BIT:  line_drive_low = cmd_reg[bit_idx_reg] ? (us_cnt_reg < US_W'(LOW1_US))
                                                     : (us_cnt_reg < US_W'(LOW0_US));
      TX_STOP: line_drive_low = (us_cnt_reg < US_W'(STOP_LOW_US));
      default: line_drive_low = 1'b0;
    endcase
  end

  assign busy        = (state_reg != IDLE);
  assign resp_valid  = resp_valid_reg;
  assign resp_data   = resp_data_reg;
  assign timeout_err = timeout_err_reg;

endmodule
